// File: rtl/matrix_stream_parser.sv
// matrix_stream_parser
// Parses an ASCII byte stream "m n e00 e01 ..." from a UART receiver and
// issues matrix-create and element-write commands to matrix storage.
// Tokens are multi-digit decimals with an optional leading '-', separated by
// space, comma, CR or LF. Dimensions and elements are range checked. If no
// element arrives for TIMEOUT_CYCLES the rest of the matrix is zero padded.
// After a matrix completes, parsing loops back for the next m until exit.
//
// Optional build macro MATRIX_PARSER_CLAMP_EN: when defined, out-of-range
// elements are saturated to ELEM_MIN/ELEM_MAX and written; when undefined
// they stop parsing with err_code 3.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_en                   level, parser enabled while high
//   rx_data, rx_done           received byte and its one-cycle strobe
//   btn_exit_input             level, leave input mode (honoured in GET_M)
//   wr_cmd_new                 pulse, create matrix wr_dims_r x wr_dims_c
//   wr_cmd_single              pulse, write wr_data at wr_row_idx/wr_col_idx
//   wr_dims_r, wr_dims_c       current matrix dimensions
//   wr_row_idx, wr_col_idx     element index of the write
//   wr_data                    signed element value
//   input_done                 high every cycle while in DONE
//   err, err_code              sticky error and its cause (1 char, 2 dim, 3 elem)
//   busy                       high in every state except IDLE
module matrix_stream_parser #(
    parameter int DATA_W         = 8,
    parameter int ROW_IDX_W      = 3,
    parameter int COL_IDX_W      = 3,
    parameter int MAX_ROWS       = 5,
    parameter int MAX_COLS       = 5,
    parameter int ELEM_MIN       = -128,
    parameter int ELEM_MAX       = 127,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_en,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    input  logic                 btn_exit_input,
    output logic                 wr_cmd_new,
    output logic                 wr_cmd_single,
    output logic [ROW_IDX_W-1:0] wr_dims_r,
    output logic [COL_IDX_W-1:0] wr_dims_c,
    output logic [ROW_IDX_W-1:0] wr_row_idx,
    output logic [COL_IDX_W-1:0] wr_col_idx,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 input_done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic                 busy
);
    localparam int AW    = DATA_W + 4;   // accumulator width
    localparam int TW    = DATA_W + 5;   // signed token width
    localparam int MW    = DATA_W + 8;   // headroom for acc*10+digit
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [MW-1:0]        ACC_LIMIT  = MW'(2 ** DATA_W);
    localparam logic signed [TW-1:0] ELEM_MIN_T = TW'(ELEM_MIN);
    localparam logic signed [TW-1:0] ELEM_MAX_T = TW'(ELEM_MAX);
    localparam logic signed [TW-1:0] MAX_ROWS_T = TW'(MAX_ROWS);
    localparam logic signed [TW-1:0] MAX_COLS_T = TW'(MAX_COLS);
    localparam logic signed [TW-1:0] ONE_T      = TW'(1);

    typedef enum logic [3:0] {
        IDLE, GET_M, GET_N, CREATE, WAIT_DATA, WRITE, PAD, NEXT, ERROR, DONE
    } state_t;

    state_t                 state_reg;
    logic [AW-1:0]          acc_reg;
    logic                   neg_reg, has_digit_reg, ovf_reg;
    logic                   tok_valid_reg, tok_err_reg, tok_neg_reg, tok_ovf_reg;
    logic signed [TW-1:0]   tok_val_reg;
    logic [TMR_W-1:0]       timer_reg;
    logic [ROW_IDX_W-1:0]   row_reg;
    logic [COL_IDX_W-1:0]   col_reg;
    logic [DATA_W-1:0]      elem_reg;
    logic                   pad_mode_reg;

    logic [MW-1:0] acc_mul;
    logic          is_digit, is_sep, pending, tok_active, timeout;
    logic          dim_r_ok, dim_c_ok, elem_ok, last_elem;
    logic [DATA_W-1:0] elem_value;

    assign is_digit   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_sep     = (rx_data == 8'h20) || (rx_data == 8'h2C) ||
                        (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign acc_mul    = MW'(acc_reg) * MW'(10) + MW'(rx_data[3:0]);
    assign pending    = has_digit_reg | neg_reg;
    assign tok_active = start_en && (state_reg != IDLE) &&
                        (state_reg != ERROR) && (state_reg != DONE);

    // A byte on the timeout cycle wins: the timer restarts instead.
    assign timeout = (state_reg == WAIT_DATA) && !pending && !rx_done &&
                     (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

    assign dim_r_ok  = !tok_ovf_reg && !tok_neg_reg &&
                       (tok_val_reg >= ONE_T) && (tok_val_reg <= MAX_ROWS_T);
    assign dim_c_ok  = !tok_ovf_reg && !tok_neg_reg &&
                       (tok_val_reg >= ONE_T) && (tok_val_reg <= MAX_COLS_T);
    assign elem_ok   = !tok_ovf_reg &&
                       (tok_val_reg >= ELEM_MIN_T) && (tok_val_reg <= ELEM_MAX_T);
    assign last_elem = (row_reg == wr_dims_r - ROW_IDX_W'(1)) &&
                       (col_reg == wr_dims_c - COL_IDX_W'(1));

    always_comb begin
        elem_value = tok_val_reg[DATA_W-1:0];
`ifdef MATRIX_PARSER_CLAMP_EN
        // Any out-of-range token is negative exactly when it carried a '-',
        // which stays true even when the accumulator overflowed.
        if (!elem_ok)
            elem_value = tok_neg_reg ? DATA_W'(ELEM_MIN) : DATA_W'(ELEM_MAX);
`endif
    end

    // Tokenizer: one result (tok_valid or tok_err) the cycle after a byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            neg_reg       <= 1'b0;
            has_digit_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            tok_valid_reg <= 1'b0;
            tok_err_reg   <= 1'b0;
            tok_neg_reg   <= 1'b0;
            tok_ovf_reg   <= 1'b0;
            tok_val_reg   <= '0;
        end else begin
            tok_valid_reg <= 1'b0;
            tok_err_reg   <= 1'b0;
            if (state_reg == IDLE || !start_en) begin
                acc_reg       <= '0;
                neg_reg       <= 1'b0;
                has_digit_reg <= 1'b0;
                ovf_reg       <= 1'b0;
            end else if (rx_done && tok_active) begin
                if (is_digit) begin
                    acc_reg       <= acc_mul[AW-1:0];
                    has_digit_reg <= 1'b1;
                    if (acc_mul > ACC_LIMIT)
                        ovf_reg <= 1'b1;
                end else if (rx_data == 8'h2D) begin
                    if (pending)
                        tok_err_reg <= 1'b1;
                    else
                        neg_reg <= 1'b1;
                end else if (is_sep) begin
                    if (has_digit_reg) begin
                        tok_valid_reg <= 1'b1;
                        tok_neg_reg   <= neg_reg;
                        tok_ovf_reg   <= ovf_reg;
                        tok_val_reg   <= neg_reg ? -$signed({1'b0, acc_reg})
                                                 :  $signed({1'b0, acc_reg});
                    end else if (neg_reg) begin
                        tok_err_reg <= 1'b1;     // lone '-'
                    end
                    acc_reg       <= '0;
                    neg_reg       <= 1'b0;
                    has_digit_reg <= 1'b0;
                    ovf_reg       <= 1'b0;
                end else begin
                    tok_err_reg <= 1'b1;
                end
            end
        end
    end

    // Idle timer: counts only while waiting for an element with nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer_reg <= '0;
        else if (state_reg != WAIT_DATA || pending || rx_done || timeout)
            timer_reg <= '0;
        else
            timer_reg <= timer_reg + TMR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_cmd_new    <= 1'b0;
            wr_cmd_single <= 1'b0;
            wr_dims_r     <= '0;
            wr_dims_c     <= '0;
            wr_row_idx    <= '0;
            wr_col_idx    <= '0;
            wr_data       <= '0;
            input_done    <= 1'b0;
            err           <= 1'b0;
            err_code      <= 2'd0;
            busy          <= 1'b0;
            row_reg       <= '0;
            col_reg       <= '0;
            elem_reg      <= '0;
            pad_mode_reg  <= 1'b0;
        end else begin
            wr_cmd_new    <= 1'b0;
            wr_cmd_single <= 1'b0;
            input_done    <= 1'b0;
            if (state_reg != IDLE && !start_en) begin
                // Abandon whatever is in flight; nothing more is written.
                state_reg    <= IDLE;
                busy         <= 1'b0;
                err          <= 1'b0;
                err_code     <= 2'd0;
                pad_mode_reg <= 1'b0;
            end else if (tok_err_reg && tok_active) begin
                state_reg <= ERROR;
                err       <= 1'b1;
                err_code  <= 2'd1;
            end else begin
                case (state_reg)
                    IDLE: if (start_en) begin
                        state_reg    <= GET_M;
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        err_code     <= 2'd0;
                        pad_mode_reg <= 1'b0;
                        row_reg      <= '0;
                        col_reg      <= '0;
                    end
                    GET_M: if (tok_valid_reg) begin
                        if (dim_r_ok) begin
                            wr_dims_r <= tok_val_reg[ROW_IDX_W-1:0];
                            state_reg <= GET_N;
                        end else begin
                            state_reg <= ERROR;
                            err       <= 1'b1;
                            err_code  <= 2'd2;
                        end
                    end else if (btn_exit_input && !pending) begin
                        state_reg  <= DONE;
                        input_done <= 1'b1;
                    end
                    GET_N: if (tok_valid_reg) begin
                        if (dim_c_ok) begin
                            wr_dims_c <= tok_val_reg[COL_IDX_W-1:0];
                            state_reg <= CREATE;
                        end else begin
                            state_reg <= ERROR;
                            err       <= 1'b1;
                            err_code  <= 2'd2;
                        end
                    end
                    CREATE: begin
                        wr_cmd_new <= 1'b1;
                        row_reg    <= '0;
                        col_reg    <= '0;
                        state_reg  <= WAIT_DATA;
                    end
                    WAIT_DATA: if (tok_valid_reg) begin
`ifdef MATRIX_PARSER_CLAMP_EN
                        elem_reg  <= elem_value;
                        state_reg <= WRITE;
`else
                        if (elem_ok) begin
                            elem_reg  <= elem_value;
                            state_reg <= WRITE;
                        end else begin
                            state_reg <= ERROR;
                            err       <= 1'b1;
                            err_code  <= 2'd3;
                        end
`endif
                    end else if (timeout) begin
                        pad_mode_reg <= 1'b1;
                        state_reg    <= PAD;
                    end
                    WRITE, PAD: begin
                        wr_cmd_single <= 1'b1;
                        wr_row_idx    <= row_reg;
                        wr_col_idx    <= col_reg;
                        wr_data       <= (state_reg == PAD) ? '0 : elem_reg;
                        state_reg     <= NEXT;
                    end
                    NEXT: if (last_elem) begin
                        pad_mode_reg <= 1'b0;
                        state_reg    <= GET_M;
                    end else begin
                        if (col_reg == wr_dims_c - COL_IDX_W'(1)) begin
                            col_reg <= '0;
                            row_reg <= row_reg + ROW_IDX_W'(1);
                        end else begin
                            col_reg <= col_reg + COL_IDX_W'(1);
                        end
                        state_reg <= pad_mode_reg ? PAD : WAIT_DATA;
                    end
                    ERROR: ;
                    DONE: input_done <= 1'b1;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matrix_stream_parser.sv
// Directed bench for matrix_stream_parser with a short idle timeout.
module tb_matrix_stream_parser;
    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst_n, start_en, rx_done, btn_exit_input;
    logic [7:0] rx_data;
    logic       wr_cmd_new, wr_cmd_single, input_done, err, busy;
    logic [2:0] wr_dims_r, wr_dims_c, wr_row_idx, wr_col_idx;
    logic [7:0] wr_data;
    logic [1:0] err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_cyc;
    int new_cnt, new_r, new_c;
    int w_cnt;
    int w_row[16], w_col[16], w_data[16], w_cyc[16];

    matrix_stream_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start_en(start_en),
        .rx_data(rx_data), .rx_done(rx_done), .btn_exit_input(btn_exit_input),
        .wr_cmd_new(wr_cmd_new), .wr_cmd_single(wr_cmd_single),
        .wr_dims_r(wr_dims_r), .wr_dims_c(wr_dims_c),
        .wr_row_idx(wr_row_idx), .wr_col_idx(wr_col_idx), .wr_data(wr_data),
        .input_done(input_done), .err(err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Command log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_cmd_new) begin
                new_cnt = new_cnt + 1;
                new_r   = int'(wr_dims_r);
                new_c   = int'(wr_dims_c);
            end
            if (wr_cmd_single && w_cnt < 16) begin
                w_row[w_cnt]  = int'(wr_row_idx);
                w_col[w_cnt]  = int'(wr_col_idx);
                w_data[w_cnt] = int'($signed(wr_data));
                w_cyc[w_cnt]  = cyc;
                w_cnt = w_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_done  = 1'b1;
        last_cyc = cyc;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic clear_log();
        new_cnt = 0;
        new_r   = 0;
        new_c   = 0;
        w_cnt   = 0;
    endtask

    task automatic restart();
        start_en = 1'b0;
        wait_cycles(3);
        start_en = 1'b1;
        wait_cycles(2);
        clear_log();
    endtask

    task automatic expect_error(input string s, input int code);
        restart();
        send_str(s);
        wait_cycles(6);
        $display("[TB] input \"%s\" -> err=%0d err_code=%0d writes=%0d", s, err, err_code, w_cnt);
        check({"err ", s}, int'(err), 1);
        check({"code ", s}, int'(err_code), code);
        check({"nowrite ", s}, w_cnt, 0);
    endtask

    initial begin
        int ev[6];
        ev = '{1, -5, 12, 0, 127, -128};
        rst_n = 1'b0; start_en = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        btn_exit_input = 1'b0;
        clear_log();
        wait_cycles(3);
        check("rst busy", int'(busy), 0);
        check("rst err", int'(err), 0);
        check("rst err_code", int'(err_code), 0);
        check("rst input_done", int'(input_done), 0);
        check("rst wr_cmd_single", int'(wr_cmd_single), 0);
        rst_n = 1'b1;
        wait_cycles(2);
        start_en = 1'b1;
        wait_cycles(2);
        check("busy after start", int'(busy), 1);

        // Full 2x3 matrix including both element bounds.
        send_str("2 3 1 -5 12 0 127 -128 ");
        wait_cycles(10);
        check("m1 new count", new_cnt, 1);
        check("m1 dims r", new_r, 2);
        check("m1 dims c", new_c, 3);
        check("m1 write count", w_cnt, 6);
        for (int i = 0; i < 6; i++) begin
            $display("[TB] write %0d: (%0d,%0d) = %0d", i, w_row[i], w_col[i], w_data[i]);
            check($sformatf("m1 row %0d", i), w_row[i], i / 3);
            check($sformatf("m1 col %0d", i), w_col[i], i % 3);
            check($sformatf("m1 data %0d", i), w_data[i], ev[i]);
        end
        check("m1 no err", int'(err), 0);

        // Next matrix follows directly (back in GET_M); idle timeout pads it.
        clear_log();
        send_str("2 2 7 ");
        check("lat sep->write", w_cyc[0] - last_cyc, 3);
        wait_cycles(TMO + 40);
        check("pad write count", w_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            $display("[TB] pad write %0d: (%0d,%0d) = %0d @%0d", i, w_row[i], w_col[i], w_data[i], w_cyc[i]);
            check($sformatf("pad row %0d", i), w_row[i], i / 2);
            check($sformatf("pad col %0d", i), w_col[i], i % 2);
            check($sformatf("pad data %0d", i), w_data[i], (i == 0) ? 7 : 0);
        end
        check("pad spacing 1", w_cyc[2] - w_cyc[1], 2);
        check("pad spacing 2", w_cyc[3] - w_cyc[2], 2);

        // Bad dimension from GET_M, then clear by dropping start_en.
        clear_log();
        send_str("6 ");
        wait_cycles(4);
        $display("[TB] input \"6 \" -> err=%0d err_code=%0d", err, err_code);
        check("dim err", int'(err), 1);
        check("dim err_code", int'(err_code), 2);
        start_en = 1'b0;
        wait_cycles(2);
        check("idle busy", int'(busy), 0);
        check("idle err cleared", int'(err), 0);
        check("idle code cleared", int'(err_code), 0);

`ifdef MATRIX_PARSER_CLAMP_EN
        restart();
        send_str("1 1 300 ");
        wait_cycles(6);
        $display("[TB] clamp \"1 1 300 \" -> writes=%0d data=%0d", w_cnt, w_data[0]);
        check("clamp writes", w_cnt, 1);
        check("clamp data", w_data[0], 127);
        check("clamp no err", int'(err), 0);
`else
        expect_error("1 1 300 ", 3);
        expect_error("1 1 -129 ", 3);
        expect_error("1 1 9999 ", 3);
`endif
        expect_error("1 2 4a", 1);
        expect_error("1 1 3-", 1);
        expect_error("1 1 - ", 1);
        expect_error("0 ", 2);

        // Exit request in GET_M.
        restart();
        btn_exit_input = 1'b1;
        wait_cycles(3);
        $display("[TB] exit -> input_done=%0d busy=%0d", input_done, busy);
        check("done input_done", int'(input_done), 1);
        check("done busy", int'(busy), 1);
        wait_cycles(3);
        check("done held", int'(input_done), 1);
        start_en = 1'b0;
        btn_exit_input = 1'b0;
        wait_cycles(2);
        check("done exit", int'(input_done), 0);

        // Asynchronous reset while waiting for element data.
        restart();
        send_str("2 2 5");
        check("pre-rst dims r", int'(wr_dims_r), 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset -> busy=%0d dims_r=%0d", busy, wr_dims_r);
        check("arst busy", int'(busy), 0);
        check("arst dims r", int'(wr_dims_r), 0);
        check("arst dims c", int'(wr_dims_c), 0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
